gtech_logic_pipe: RTL and testbench

- Parametrised, pipelined successor to the single-bit inverted-input OR generic cell.
- Applies a selectable two-operand bitwise function with inverted B to WIDTH-bit vectors:
  - OR-NOT
  - AND-NOT
  - XNOR
  - NOR-NOT
- The result passes through STAGES registered stages with valid/ready flow control.
- Sits between the generic-cell library and datapath blocks that need a retimable, back-pressurable logic slice.

---
 rtl/gtech_logic_pkg.sv | 17 +
 rtl/gtech_logic_stage.sv | 31 +++
 rtl/gtech_logic_pipe.sv | 68 ++++++
 tb/tb_gtech_logic_pipe.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/gtech_logic_pkg.sv
// gtech_logic_pkg: MODE encoding and the per-bit inverted-B logic function used by gtech_logic_pipe
package gtech_logic_pkg;
  typedef enum logic [1:0] {
    MODE_OR_NOT   = 2'd0,
    MODE_AND_NOT  = 2'd1,
    MODE_XNOR_NOT = 2'd2,
    MODE_NOR_NOT  = 2'd3
  } mode_e;
  // single-bit operation; callers apply it across any width with a generate loop
  function automatic logic logic_op(input mode_e mode, input logic a, input logic b);
    logic nb;
    nb = ~b;
    return mode == MODE_OR_NOT  ? (a | nb) :
           mode == MODE_AND_NOT ? (a & nb) :
           mode == MODE_XNOR_NOT ? ~(a ^ nb) : ~(a | nb);
  endfunction
endpackage

// File: rtl/gtech_logic_stage.sv
// gtech_logic_stage: one valid/ready register stage of W-bit payload
//   CLK/RST: clock, sync active-high reset
//   i_valid/i_data: upstream payload; i_ready: downstream stage can take data
//   o_valid/o_data: registered payload
module gtech_logic_stage #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         i_valid,
  input  logic [W-1:0] i_data,
  input  logic         i_ready,
  output logic         o_valid,
  output logic [W-1:0] o_data
);
  logic         r_valid;
  logic [W-1:0] r_data;
  logic         w_load;
  assign w_load  = ~r_valid | i_ready;
  assign o_valid = r_valid;
  assign o_data  = r_data;
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (w_load) begin
      r_valid <= i_valid;
      if (i_valid) r_data <= i_data;
    end
  end
endmodule

// File: rtl/gtech_logic_pipe.sv
// gtech_logic_pipe: selectable inverted-B bitwise function feeding a STAGES-deep valid/ready pipeline
//   CLK/RST: clock, sync active-high reset
//   MODE/A/B/IN_VALID/IN_READY: input handshake; Z/OUT_VALID/OUT_READY: output handshake
//   XFER_CNT: wrapping count of accepted input transfers
//   GTECH_LOGIC_PIPE_PARITY_EN adds Z_PAR, the even parity of Z carried through the pipe alongside it
module gtech_logic_pipe
  import gtech_logic_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2,
  parameter int CNT_W  = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [1:0]       MODE,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] Z,
`ifdef GTECH_LOGIC_PIPE_PARITY_EN
  output logic             Z_PAR,
`endif
  output logic [CNT_W-1:0] XFER_CNT
);
`ifdef GTECH_LOGIC_PIPE_PARITY_EN
  localparam int PW = WIDTH + 1;
`else
  localparam int PW = WIDTH;
`endif
  logic [WIDTH-1:0] w_op;
  logic [STAGES:0]  w_valid;
  logic [STAGES:0]  w_rdy;
  logic [PW-1:0]    w_data [STAGES+1];
  logic [CNT_W-1:0] r_xfer_cnt;
  for (genvar i = 0; i < WIDTH; i++) begin : g_op
    assign w_op[i] = logic_op(mode_e'(MODE), A[i], B[i]);
  end
`ifdef GTECH_LOGIC_PIPE_PARITY_EN
  assign w_data[0]    = {^w_op, w_op};
  assign {Z_PAR, Z}   = w_data[STAGES];
`else
  assign w_data[0]    = w_op;
  assign Z            = w_data[STAGES];
`endif
  assign w_valid[0]     = IN_VALID;
  assign w_rdy[STAGES]  = OUT_READY;
  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    // ready_s unrolled over the registered valids: loads if any later stage is empty or the sink accepts
    assign w_rdy[s] = OUT_READY | ~&w_valid[STAGES:s+1];
    gtech_logic_stage #(.W(PW)) u_stage (
      .CLK     (CLK),
      .RST     (RST),
      .i_valid (w_valid[s]),
      .i_data  (w_data[s]),
      .i_ready (w_rdy[s+1]),
      .o_valid (w_valid[s+1]),
      .o_data  (w_data[s+1])
    );
  end
  assign IN_READY  = w_rdy[0] & ~RST;
  assign OUT_VALID = w_valid[STAGES];
  assign XFER_CNT  = r_xfer_cnt;
  always_ff @(posedge CLK)
    r_xfer_cnt <= RST ? '0 : r_xfer_cnt + CNT_W'(IN_VALID & IN_READY);
endmodule

// File: tb/tb_gtech_logic_pipe.sv
// tb_gtech_logic_pipe: scoreboard bench for gtech_logic_pipe (optionally with GTECH_LOGIC_PIPE_PARITY_EN)
module tb_gtech_logic_pipe;
  localparam int W = 8;
  localparam int S = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] mode;
  logic in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] a, b, z;
  logic [15:0] xfer;
  logic [1:0] w_mode;
  logic w_in_valid, w_in_ready, w_out_valid, w_out_ready;
  logic [W-1:0] w_a, w_b, w_z;
  logic [3:0] w_xfer;
`ifdef GTECH_LOGIC_PIPE_PARITY_EN
  logic z_par, w_z_par;
`endif
  typedef struct {
    logic [W-1:0] z;
    logic         par;
    logic         lat;
    int           cyc;
  } exp_t;
  exp_t q[$];
  exp_t mon_e;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  gtech_logic_pipe #(.WIDTH(W), .STAGES(S), .CNT_W(16)) dut (
    .CLK(clk), .RST(rst), .MODE(mode), .IN_VALID(in_valid), .IN_READY(in_ready),
    .A(a), .B(b), .OUT_VALID(out_valid), .OUT_READY(out_ready), .Z(z),
`ifdef GTECH_LOGIC_PIPE_PARITY_EN
    .Z_PAR(z_par),
`endif
    .XFER_CNT(xfer)
  );
  gtech_logic_pipe #(.WIDTH(W), .STAGES(S), .CNT_W(4)) dut_wrap (
    .CLK(clk), .RST(rst), .MODE(w_mode), .IN_VALID(w_in_valid), .IN_READY(w_in_ready),
    .A(w_a), .B(w_b), .OUT_VALID(w_out_valid), .OUT_READY(w_out_ready), .Z(w_z),
`ifdef GTECH_LOGIC_PIPE_PARITY_EN
    .Z_PAR(w_z_par),
`endif
    .XFER_CNT(w_xfer)
  );
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", n, act, exp);
    end
  endtask
  function automatic logic [W-1:0] model(input logic [1:0] m, input logic [W-1:0] x, input logic [W-1:0] y);
    case (m)
      2'd0:    return x | ~y;
      2'd1:    return x & ~y;
      2'd2:    return x ^ y;
      default: return ~x & y;
    endcase
  endfunction
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  // called at posedge+1; leaves at posedge+1 right after the accepting edge
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic [1:0] tm,
                      input logic [W-1:0] ez, input logic lat);
    int n;
    n = 0;
    a = ta; b = tb; mode = tm; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("accept_timeout", 32'd0, 32'd1);
    else q.push_back('{z: ez, par: ^ez, lat: lat, cyc: cyc});
    step();
    in_valid = 1'b0;
  endtask
  task automatic drain;
    int n;
    n = 0;
    while (q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", q.size(), 0);
    step();
  endtask
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) chk("unexpected_out", 32'd1, 32'd0);
      else begin
        mon_e = q.pop_front();
        chk("z", z, mon_e.z);
`ifdef GTECH_LOGIC_PIPE_PARITY_EN
        chk("z_par", z_par, mon_e.par);
`endif
        if (mon_e.lat) chk("latency", cyc - mon_e.cyc, S);
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    int t0;
    logic [W-1:0] ra, rb;
    logic [1:0] rm;
    in_valid = 0; a = '0; b = '0; mode = '0; out_ready = 0;
    w_in_valid = 0; w_a = 8'hA5; w_b = 8'h0F; w_mode = 2'd3; w_out_ready = 1;
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_z", z, 8'h00);
    chk("rst_xfer", xfer, 0);
    chk("rst_in_ready", in_ready, 1);
    step();
    out_ready = 1;
    send(8'hA5, 8'h0F, 2'd0, 8'hF5, 1);
    send(8'hA5, 8'h0F, 2'd1, 8'hA0, 1);
    send(8'hA5, 8'h0F, 2'd2, 8'hAA, 1);
    send(8'hA5, 8'h0F, 2'd3, 8'h0A, 1);
    send(8'h01, 8'hFF, 2'd0, 8'h01, 1);
    drain();
    chk("mode_xfer", xfer, 5);
    out_ready = 0;
    send(8'h3C, 8'h55, 2'd1, 8'h28, 0);
    send(8'hF0, 8'h0F, 2'd2, 8'hFF, 0);
    a = 8'h81; b = 8'h7E; mode = 2'd0; in_valid = 1;
    @(negedge clk);
    chk("stall_in_ready", in_ready, 0);
    chk("stall_out_valid", out_valid, 1);
    chk("stall_z", z, 8'h28);
    repeat (2) @(negedge clk);
    chk("hold_out_valid", out_valid, 1);
    chk("hold_z", z, 8'h28);
    chk("hold_xfer", xfer, 7);
    step();
    out_ready = 1;
    send(8'h81, 8'h7E, 2'd0, 8'h81, 0);
    drain();
    rst = 1;
    q.delete();
    step();
    rst = 0;
    t0 = cyc;
    for (int i = 0; i < 100; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rm = 2'($urandom_range(0, 3));
      send(ra, rb, rm, model(rm, ra, rb), 1);
    end
    chk("stream_cycles", cyc - t0, 100);
    drain();
    chk("stream_xfer", xfer, 100);
    out_ready = 0;
    send(8'h12, 8'h34, 2'd2, 8'h26, 0);
    send(8'h56, 8'h78, 2'd1, 8'h06, 0);
    rst = 1;
    q.delete();
    @(negedge clk);
    chk("rst_cycle_in_ready", in_ready, 0);
    step();
    rst = 0;
    out_ready = 1;
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_xfer", xfer, 0);
    chk("midrst_in_ready", in_ready, 1);
    repeat (4) @(negedge clk);
    step();
    w_in_valid = 1;
    repeat (17) step();
    w_in_valid = 0;
    chk("wrap_xfer", w_xfer, 1);
    repeat (3) step();
    chk("wrap_z", w_z, 8'h0A);
    chk("wrap_out_valid", w_out_valid, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
